// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI serf.
package spi_pkg;

   localparam int SPI_W = 16;

   typedef enum logic {IDLE, SHIFT} serf_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous input, with level and edge strobes.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic ff1, ff2, ff3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1 <= RST_VAL;
         ff2 <= RST_VAL;
         ff3 <= RST_VAL;
      end else begin
         ff1 <= async_in;
         ff2 <= ff1;
         ff3 <= ff2;
      end
   end

   assign level = ff2;
   assign rise  = ff2 & ~ff3;
   assign fall  = ~ff2 & ff3;

endmodule

// File: rtl/spi_serf.sv
// SPI serf: shifts a frame in on MOSI while returning a preloaded word on MISO,
// running entirely on the system clock with synchronized SS_n/SCLK/MOSI.
module spi_serf
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              wrt,
   output logic [DATA_W-1:0] rx_data,
   output logic              rdy,
   output logic              frm_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_edges;

   serf_state_t       state;
   logic [CNT_W-1:0]  rise_cnt;
   logic              seen_rise;
   logic              mosi_smpl;
   logic [DATA_W-1:0] shft_reg;
   logic [DATA_W-1:0] tx_hold;
   logic [1:0]        warm_cnt;
   logic              ss_armed;

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (SS_n),
      .level    (ss_lvl),
      .rise     (ss_rise),
      .fall     (ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (SCLK),
      .level    (sclk_lvl),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (MOSI),
      .level    (mosi_lvl),
      .rise     (mosi_rise),
      .fall     (mosi_fall)
   );

   assign unused_edges = sclk_lvl ^ mosi_rise ^ mosi_fall;

   // A reset released while SS_n is low would look like an SS_n fall once the
   // chain refills; only accept falls after SS_n has been seen genuinely high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt <= 2'd0;
         ss_armed <= 1'b0;
      end else begin
         if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
         if (warm_cnt == 2'd3 && ss_lvl) ss_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_hold <= '0;
      end else if (wrt) begin
         tx_hold <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rise_cnt  <= '0;
         seen_rise <= 1'b0;
         mosi_smpl <= 1'b0;
         shft_reg  <= '0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         rdy     <= 1'b0;
         frm_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall && ss_armed) begin
                  shft_reg  <= wrt ? tx_data : tx_hold;
                  rise_cnt  <= '0;
                  seen_rise <= 1'b0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  state <= IDLE;
                  if (rise_cnt == CNT_FULL) begin
                     rx_data <= {shft_reg[DATA_W-2:0], mosi_smpl};
                     rdy     <= 1'b1;
                  end else begin
                     frm_err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  mosi_smpl <= mosi_lvl;
                  seen_rise <= 1'b1;
                  if (rise_cnt != CNT_FULL) rise_cnt <= rise_cnt + 1'b1;
               end else if (sclk_fall && seen_rise) begin
                  shft_reg <= {shft_reg[DATA_W-2:0], mosi_smpl};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MISO = shft_reg[DATA_W-1];
   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a bench-side monarch drives frames, a scoreboard
// checks every rdy/frm_err pulse against expectations queued with the stimulus.
module tb_spi_serf;

   localparam int WRT_AT_FALL = 100;

   logic        clk;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [15:0] tx_data;
   logic        wrt;
   logic [15:0] rx_data;
   logic        rdy;
   logic        frm_err;
   logic        busy;

   typedef struct {
      logic        err;
      logic [15:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   spi_serf #(.DATA_W(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .tx_data (tx_data),
      .wrt     (wrt),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every flag pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rdy || frm_err) begin
         if (exp_q.size() == 0) begin
            check("unexpected_flag", {30'd0, rdy, frm_err}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("flag_kind", {30'd0, rdy, frm_err}, e.err ? 32'd1 : 32'd2);
            check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
         end
      end
   end

   task automatic do_wrt(input logic [15:0] val);
      @(negedge clk);
      tx_data = val;
      wrt     = 1'b1;
      @(negedge clk);
      wrt     = 1'b0;
   endtask

   task automatic push_ev(input logic err, input logic [15:0] data);
      ev_t e;
      e.err  = err;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monarch model: leading SCLK fall, nbits rises, SS_n rises after the last rise.
   task automatic frame(input logic [15:0] mo, input int nbits, input int wrt_at,
                        input logic [15:0] wval, input int rst_at, output logic [15:0] mi);
      mi = '0;
      @(negedge clk);
      SS_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (wrt_at == WRT_AT_FALL) begin
         tx_data = wval;
         wrt     = 1'b1;
         @(negedge clk);
         wrt     = 1'b0;
      end
      repeat (6) @(negedge clk);
      SCLK = 1'b0;
      MOSI = mo[15];
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) begin
            SCLK = 1'b0;
            MOSI = mo[15-i];
            repeat (8) @(negedge clk);
         end
         SCLK = 1'b1;
         mi   = {mi[14:0], MISO};
         if (i == 1 && rst_at < 0) check("busy_mid", {31'd0, busy}, 32'd1);
         repeat (8) @(negedge clk);
         if (i == wrt_at) begin
            tx_data = wval;
            wrt     = 1'b1;
            @(negedge clk);
            wrt     = 1'b0;
         end
         if (i == rst_at) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      end
      if (rst_at >= 0) check("busy_after_rst", {31'd0, busy}, 32'd0);
      SS_n = 1'b1;
      // Bounded wait for the scoreboard to drain, then idle long enough to catch strays.
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      check("drain", exp_q.size(), 32'd0);
      repeat (10) @(negedge clk);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      rst_n   = 1'b0;
      SS_n    = 1'b1;
      SCLK    = 1'b1;
      MOSI    = 1'b0;
      wrt     = 1'b0;
      tx_data = '0;
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, MISO}, 32'd0);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      check("rst_frm_err", {31'd0, frm_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rx_data", {16'd0, rx_data}, 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Loopback
      do_wrt(16'hA5C3);
      push_ev(1'b0, 16'h8F00);
      frame(16'h8F00, 16, -1, 16'h0, -1, rd);
      check("loop_rd", {16'd0, rd}, 32'h0000_A5C3);

      // Back-to-back with a mid-frame write
      do_wrt(16'h1111);
      push_ev(1'b0, 16'h3C5A);
      frame(16'h3C5A, 16, 4, 16'h1234, -1, rd);
      check("b2b1_rd", {16'd0, rd}, 32'h0000_1111);
      push_ev(1'b0, 16'h0F0F);
      frame(16'h0F0F, 16, -1, 16'h0, -1, rd);
      check("b2b2_rd", {16'd0, rd}, 32'h0000_1234);

      // Truncated frame: frm_err with rx_data held
      push_ev(1'b1, 16'h0F0F);
      frame(16'hFFFF, 7, -1, 16'h0, -1, rd);
      check("trunc_hold", {16'd0, rx_data}, 32'h0000_0F0F);
      push_ev(1'b0, 16'hC001);
      frame(16'hC001, 16, -1, 16'h0, -1, rd);
      check("after_trunc_rd", {16'd0, rd}, 32'h0000_1234);

      // Reset mid-frame, released while SS_n still low
      frame(16'hAAAA, 16, -1, 16'h0, 4, rd);
      check("rst_mid_rx", {16'd0, rx_data}, 32'd0);
      push_ev(1'b0, 16'h00FF);
      frame(16'h00FF, 16, -1, 16'h0, -1, rd);
      check("after_rst_rd", {16'd0, rd}, 32'd0);

      // Write coincident with SS_n fall detect bypasses tx_hold
      do_wrt(16'h5555);
      push_ev(1'b0, 16'h1357);
      frame(16'h1357, 16, WRT_AT_FALL, 16'hBEEF, -1, rd);
      check("bypass_rd", {16'd0, rd}, 32'h0000_BEEF);
      push_ev(1'b0, 16'h2468);
      frame(16'h2468, 16, -1, 16'h0, -1, rd);
      check("bypass_hold_rd", {16'd0, rd}, 32'h0000_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
